// File: rtl/adder_sub_pkg.sv
// Shared types, default sizes and the saturation helper for the chunk-serial
// adder/subtractor.
package adder_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;
    localparam int MAX_WIDTH = 64;

    // Most negative value for a negative A, most positive otherwise; the
    // caller truncates to its own width.
    function automatic logic [MAX_WIDTH-1:0] sat_value(input logic sign, input int width);
        logic [MAX_WIDTH-1:0] msb_only;
        msb_only = {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
        return sign ? msb_only : (msb_only - {{(MAX_WIDTH-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/adder_sub_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its top
// bit so the caller can derive signed overflow on the last chunk.
module adder_sub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
            full_adder u_fa (
                .a    (a[gi]),
                .b    (b[gi]),
                .cin  (carry[gi]),
                .sum  (sum[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    assign cout     = carry[CHUNK];
    assign c_msb_in = carry[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/adder_sub_seq.sv
// Chunk-serial adder/subtractor: one CHUNK-bit ripple stage reused over
// WIDTH/CHUNK cycles, LSB chunk first, with valid/ready on both sides.
module adder_sub_seq
    import adder_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b1,
    input  logic             sub,
    input  logic             use_cin,
    input  logic             cin,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int K_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NCH - 1);

    state_t           state_reg, state_next;
    logic [K_W-1:0]   k_reg, k_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] res_reg, res_next;
    logic             carry_reg, carry_next;
    logic             sat_reg, sat_next;
    logic [WIDTH-1:0] out_reg, out_next;
    logic             cout_reg, cout_next;
    logic             ovf_reg, ovf_next;
    logic             zero_reg, zero_next;

    logic [CHUNK-1:0] chunk_a, chunk_b, chunk_sum;
    logic             chunk_cout, chunk_cmsb;
    logic             ovf_v;
    logic [WIDTH-1:0] final_v;

    assign chunk_a = a_reg[int'(k_reg)*CHUNK +: CHUNK];
    assign chunk_b = b_reg[int'(k_reg)*CHUNK +: CHUNK];

    adder_sub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a        (chunk_a),
        .b        (chunk_b),
        .cin      (carry_reg),
        .sum      (chunk_sum),
        .cout     (chunk_cout),
        .c_msb_in (chunk_cmsb)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            k_reg     <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            sat_reg   <= 1'b0;
            out_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            zero_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            res_reg   <= res_next;
            carry_reg <= carry_next;
            sat_reg   <= sat_next;
            out_reg   <= out_next;
            cout_reg  <= cout_next;
            ovf_reg   <= ovf_next;
            zero_reg  <= zero_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        res_next   = res_reg;
        carry_next = carry_reg;
        sat_next   = sat_reg;
        out_next   = out_reg;
        cout_next  = cout_reg;
        ovf_next   = ovf_reg;
        zero_next  = zero_reg;
        ovf_v      = 1'b0;
        final_v    = res_reg;

        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    a_next     = a;
                    b_next     = b1 ^ {WIDTH{sub}};
                    carry_next = use_cin ? cin : sub;
                    sat_next   = sat;
                    k_next     = '0;
                    res_next   = '0;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                res_next[int'(k_reg)*CHUNK +: CHUNK] = chunk_sum;
                carry_next = chunk_cout;
                k_next     = k_reg + K_W'(1);
                if (k_reg == K_LAST) begin
                    // Flags describe the unsaturated sum; zero looks at what is driven out.
                    ovf_v      = chunk_cmsb ^ chunk_cout;
                    final_v    = (sat_reg && ovf_v) ? WIDTH'(sat_value(a_reg[WIDTH-1], WIDTH))
                                                    : res_next;
                    out_next   = final_v;
                    cout_next  = chunk_cout;
                    ovf_next   = ovf_v;
                    zero_next  = (final_v == '0);
                    k_next     = '0;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign out       = out_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_adder_sub_seq.sv
// Scoreboard bench for adder_sub_seq at WIDTH=16, CHUNK=4: the driver pushes
// hand-computed results, a negedge monitor pops them on each output handshake.
module tb_adder_sub_seq;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int NCH   = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b1;
    logic             sub;
    logic             use_cin;
    logic             cin;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             ovf;
    logic             zero;

    adder_sub_seq #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b1        (b1),
        .sub       (sub),
        .use_cin   (use_cin),
        .cin       (cin),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] out;
        logic             cout;
        logic             ovf;
        logic             zero;
        int               acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   lat_done   = 1'b0;
    bit   stray_seen = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: latency on first presentation, full compare on the handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                if (!stray_seen) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL unexpected_result: got out_valid=1 out=0x%0h, expected no result", out);
                    stray_seen = 1'b1;
                end
            end else begin
                if (!lat_done) begin
                    check({exp_q[0].name, ".latency"}, 32'(cyc - exp_q[0].acc_cyc), 32'(NCH));
                    lat_done = 1'b1;
                end
                if (out_ready) begin
                    e = exp_q.pop_front();
                    check({e.name, ".out"},  32'(out),  32'(e.out));
                    check({e.name, ".cout"}, 32'(cout), 32'(e.cout));
                    check({e.name, ".ovf"},  32'(ovf),  32'(e.ovf));
                    check({e.name, ".zero"}, 32'(zero), 32'(e.zero));
                    $display("txn %-10s out=0x%04h cout=%0b ovf=%0b zero=%0b", e.name, out, cout, ovf, zero);
                    lat_done = 1'b0;
                end
            end
        end else begin
            stray_seen = 1'b0;
        end
    end

    task automatic issue(input string name, input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                         input logic s, input logic uc, input logic ci, input logic st, input bit push,
                         input logic [WIDTH-1:0] eo, input logic ec, input logic ev, input logic ez);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        if (!in_ready) check({name, ".in_ready_timeout"}, 32'(in_ready), 32'd1);
        a = a_v; b1 = b_v; sub = s; use_cin = uc; cin = ci; sat = st;
        in_valid = 1'b1;
        if (push) begin
            e.name = name; e.out = eo; e.cout = ec; e.ovf = ev; e.zero = ez;
            e.acc_cyc = cyc + 1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = '0; b1 = '0;
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        if (exp_q.size() != 0) begin
            check({name, ".result_timeout"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b1 = '0;
        sub = 1'b0; use_cin = 1'b0; cin = 1'b0; sat = 1'b0; out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.out",       32'(out),       32'h0);
        check("reset.flags",     32'({cout, ovf, zero}), 32'h0);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.in_ready",  32'(in_ready),  32'd1);
        rst_n = 1'b1;

        issue("add",      16'h1234, 16'h0FF1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h2225, 1'b0, 1'b0, 1'b0);
        wait_empty("add");
        issue("sub_eq",   16'h0005, 16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        wait_empty("sub_eq");
        issue("sub_bor",  16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        wait_empty("sub_bor");
        issue("ovf_wrap", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
        wait_empty("ovf_wrap");
        issue("ovf_satp", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        wait_empty("ovf_satp");
        issue("ovf_satn", 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
        wait_empty("ovf_satn");
        issue("sat_zero", 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
        wait_empty("sat_zero");
        issue("chain",    16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        wait_empty("chain");
        issue("sub_cin0", 16'h0010, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h000E, 1'b1, 1'b0, 1'b0);
        wait_empty("sub_cin0");

        // Backpressure: result held while out_ready is low, extra in_valid ignored.
        #1 out_ready = 1'b0;
        issue("bp",       16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n = n + 1;
        end
        for (int i = 0; i < 3; i++) begin
            check("bp.hold_out",      32'(out),       32'h3333);
            check("bp.hold_flags",    32'({cout, ovf, zero}), 32'h0);
            check("bp.hold_valid",    32'(out_valid), 32'd1);
            check("bp.hold_in_ready", 32'(in_ready),  32'd0);
            if (i == 1) begin
                a = 16'h0001; b1 = 16'h0001; sub = 1'b0; use_cin = 1'b0; sat = 1'b0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp.release_valid",    32'(out_valid), 32'd0);
        check("bp.release_in_ready", 32'(in_ready),  32'd1);
        check("bp.release_out_kept", 32'(out),       32'h3333);
        wait_empty("bp");
        repeat (NCH + 2) @(negedge clk);

        // Reset two RUN cycles into an operation; nothing may come out of it.
        issue("aborted",  16'h1234, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst.out",       32'(out),       32'h0);
        check("midrst.flags",     32'({cout, ovf, zero}), 32'h0);
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.in_ready",  32'(in_ready),  32'd1);
        issue("post_rst", 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b0, 1'b0);
        wait_empty("post_rst");
        repeat (NCH + 2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
